// File: rtl/axi_ax_buffer_ot_if.sv
// AXI address-channel (AR/AW) bundle: valid/ready handshake plus the full AX payload.
interface axi_ax_buffer_ot_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6
);
  logic                  valid;
  logic                  ready;
  logic [ADDR_WIDTH-1:0] addr;
  logic [2:0]            prot;
  logic [3:0]            region;
  logic [7:0]            len;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic                  lock;
  logic [3:0]            cache;
  logic [3:0]            qos;
  logic [ID_WIDTH-1:0]   id;
  logic [USER_WIDTH-1:0] user;

  modport master (
    output valid, addr, prot, region, len, size, burst, lock, cache, qos, id, user,
    input  ready
  );

  modport slave (
    input  valid, addr, prot, region, len, size, burst, lock, cache, qos, id, user,
    output ready
  );
endinterface

// File: rtl/axi_ax_buffer_ot.sv
// AX-channel FIFO buffer with optional fall-through from empty and a limiter on
// the number of issued bursts still waiting for their completion pulse.
module axi_ax_buffer_ot #(
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int USER_WIDTH      = 6,
  parameter int BUFFER_DEPTH    = 4,
  parameter int FALL_THROUGH    = 0,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  axi_ax_buffer_ot_if.slave                      slv,
  axi_ax_buffer_ot_if.master                     mst,
  input  logic                                   done_i,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]      fill_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   full_o,
  output logic                                   empty_o
);

  localparam int W  = 29 + ADDR_WIDTH + USER_WIDTH + ID_WIDTH;
  localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int FW = $clog2(BUFFER_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [W-1:0]  mem [BUFFER_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] fill_q;
  logic [OW-1:0] out_q;

  logic [W-1:0]  slv_payload, mst_payload;
  logic          issue_ok, bypass, slv_ready, mst_valid;
  logic          s_hs, m_hs, push, pop, done_eff;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign slv_payload = {slv.addr, slv.prot, slv.region, slv.len, slv.size, slv.burst,
                        slv.lock, slv.cache, slv.qos, slv.id, slv.user};

  assign full_o        = (fill_q == FW'(BUFFER_DEPTH));
  assign empty_o       = (fill_q == '0);
  assign fill_o        = fill_q;
  assign outstanding_o = out_q;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high.
  // Ready depends only on stored state, never on the downstream ready.
  assign issue_ok  = (out_q < OW'(MAX_OUTSTANDING));
  assign bypass    = (FALL_THROUGH != 0) && empty_o;
  assign slv_ready = rst_ni && !full_o;
  assign mst_valid = rst_ni && issue_ok && (bypass ? slv.valid : !empty_o);

  assign mst_payload = bypass ? slv_payload : mem[rd_ptr];

  assign s_hs     = slv.valid && slv_ready;
  assign m_hs     = mst_valid && mst.ready;
  // A bypassed request that is taken downstream in the same cycle is never stored.
  assign push     = s_hs && !(bypass && m_hs);
  assign pop      = m_hs && !bypass;
  assign done_eff = done_i && (out_q != '0);

  assign slv.ready = slv_ready;
  assign mst.valid = mst_valid;
  assign {mst.addr, mst.prot, mst.region, mst.len, mst.size, mst.burst,
          mst.lock, mst.cache, mst.qos, mst.id, mst.user} = mst_payload;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= slv_payload;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_q <= '0;
      out_q  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fill_q <= fill_q + FW'(1);
        2'b01:   fill_q <= fill_q - FW'(1);
        default: fill_q <= fill_q;
      endcase
      case ({m_hs, done_eff})
        2'b10:   out_q <= out_q + OW'(1);
        2'b01:   out_q <= out_q - OW'(1);
        default: out_q <= out_q;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ax_buffer_ot.sv
// Bench for axi_ax_buffer_ot: three configurations (D4/FT0/M8, D4/FT1/M2, D3/FT0/M8)
// driven from a vector table plus hand-written wrap and reset sequences.
module tb_axi_ax_buffer_ot;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_valid [3];
  logic [31:0] s_addr  [3];
  logic [3:0]  s_id    [3];
  logic [7:0]  s_len   [3];
  logic        m_ready [3];
  logic        done    [3];

  logic        s_ready [3];
  logic        m_valid [3];
  logic [31:0] m_addr  [3];
  logic [3:0]  m_id    [3];
  logic [7:0]  m_len   [3];
  logic [3:0]  fill    [3];
  logic [3:0]  outst   [3];
  logic        full    [3];
  logic        empty   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DEP = (g == 2) ? 3 : 4;
    localparam int FT  = (g == 1) ? 1 : 0;
    localparam int MO  = (g == 1) ? 2 : 8;

    axi_ax_buffer_ot_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6)) slv_if ();
    axi_ax_buffer_ot_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6)) mst_if ();

    logic [$clog2(DEP+1)-1:0] fill_w;
    logic [$clog2(MO+1)-1:0]  out_w;
    logic                     full_w, empty_w;

    assign slv_if.valid  = s_valid[g];
    assign slv_if.addr   = s_addr[g];
    assign slv_if.prot   = s_id[g][2:0];
    assign slv_if.region = 4'h0;
    assign slv_if.len    = s_len[g];
    assign slv_if.size   = 3'd2;
    assign slv_if.burst  = 2'b01;
    assign slv_if.lock   = 1'b0;
    assign slv_if.cache  = 4'h3;
    assign slv_if.qos    = 4'h0;
    assign slv_if.id     = s_id[g];
    assign slv_if.user   = 6'h15;
    assign mst_if.ready  = m_ready[g];

    assign s_ready[g] = slv_if.ready;
    assign m_valid[g] = mst_if.valid;
    assign m_addr[g]  = mst_if.addr;
    assign m_id[g]    = mst_if.id;
    assign m_len[g]   = mst_if.len;
    assign fill[g]    = 4'(fill_w);
    assign outst[g]   = 4'(out_w);
    assign full[g]    = full_w;
    assign empty[g]   = empty_w;

    axi_ax_buffer_ot #(
      .ID_WIDTH(4), .ADDR_WIDTH(32), .USER_WIDTH(6),
      .BUFFER_DEPTH(DEP), .FALL_THROUGH(FT), .MAX_OUTSTANDING(MO)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .slv(slv_if), .mst(mst_if), .done_i(done[g]),
      .fill_o(fill_w), .outstanding_o(out_w), .full_o(full_w), .empty_o(empty_w)
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [3:0] id);
    return 32'h1000 + 32'(id) * 32'h10;
  endfunction

  function automatic logic [7:0] len_of(input logic [3:0] id);
    return 8'(id) + 8'd1;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < 3; i++) begin
      s_valid[i] = 1'b0; s_addr[i] = '0; s_id[i] = '0; s_len[i] = '0;
      m_ready[i] = 1'b0; done[i] = 1'b0;
    end
  endtask

  task automatic drive(input int inst, input bit sv, input logic [3:0] id, input bit mr, input bit dn);
    clear_inputs();
    s_valid[inst] = sv;
    s_id[inst]    = id;
    s_addr[inst]  = addr_of(id);
    s_len[inst]   = len_of(id);
    m_ready[inst] = mr;
    done[inst]    = dn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    int         inst;
    bit         sv;
    logic [3:0] id;
    bit         mr;
    bit         dn;
    bit         esr;
    bit         emv;
    logic [3:0] eid;
    int         efill;
    int         eout;
    bit         efull;
    bit         eempty;
  } vec_t;

  function automatic vec_t v(input int inst, input bit sv, input int id, input bit mr, input bit dn,
                             input bit esr, input bit emv, input int eid, input int efill,
                             input int eout, input bit efull, input bit eempty);
    vec_t r;
    r.inst = inst; r.sv = sv; r.id = 4'(id); r.mr = mr; r.dn = dn;
    r.esr = esr; r.emv = emv; r.eid = 4'(eid); r.efill = efill; r.eout = eout;
    r.efull = efull; r.eempty = eempty;
    return r;
  endfunction

  vec_t        tbl[$];
  logic [31:0] exp_q[$];

  initial begin
    // inst, sv, id, mr, dn | s_ready, m_valid, m_id, fill, outstanding, full, empty
    tbl.push_back(v(0,0,0,0,0, 1,0,0,0,0,0,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0,1));
    tbl.push_back(v(2,0,0,0,0, 1,0,0,0,0,0,1));
    // depth 4, no fall-through: fill to full, refuse while full, drain in order
    tbl.push_back(v(0,1,0,0,0, 1,0,0,0,0,0,1));
    tbl.push_back(v(0,1,1,0,0, 1,1,0,1,0,0,0));
    tbl.push_back(v(0,1,2,0,0, 1,1,0,2,0,0,0));
    tbl.push_back(v(0,1,3,0,0, 1,1,0,3,0,0,0));
    tbl.push_back(v(0,0,0,0,0, 0,1,0,4,0,1,0));
    tbl.push_back(v(0,1,9,1,0, 0,1,0,4,0,1,0));
    tbl.push_back(v(0,0,0,1,0, 1,1,1,3,1,0,0));
    tbl.push_back(v(0,0,0,1,0, 1,1,2,2,2,0,0));
    tbl.push_back(v(0,0,0,1,0, 1,1,3,1,3,0,0));
    tbl.push_back(v(0,0,0,1,0, 1,0,0,0,4,0,1));
    tbl.push_back(v(0,0,0,0,1, 1,0,0,0,4,0,1));
    tbl.push_back(v(0,1,5,0,0, 1,0,0,0,3,0,1));
    tbl.push_back(v(0,1,6,1,0, 1,1,5,1,3,0,0));
    tbl.push_back(v(0,0,0,0,0, 1,1,6,1,4,0,0));
    // fall-through, limit 2: bypass, done/handshake collisions, throttling
    tbl.push_back(v(1,1,0,1,0, 1,1,0,0,0,0,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,1,0,1));
    tbl.push_back(v(1,1,1,1,1, 1,1,1,0,1,0,1));
    tbl.push_back(v(1,0,0,0,1, 1,0,0,0,1,0,1));
    tbl.push_back(v(1,0,0,0,1, 1,0,0,0,0,0,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0,1));
    tbl.push_back(v(1,1,2,0,0, 1,1,2,0,0,0,1));
    tbl.push_back(v(1,1,3,0,0, 1,1,2,1,0,0,0));
    tbl.push_back(v(1,1,4,0,0, 1,1,2,2,0,0,0));
    tbl.push_back(v(1,0,0,1,0, 1,1,2,3,0,0,0));
    tbl.push_back(v(1,0,0,1,0, 1,1,3,2,1,0,0));
    tbl.push_back(v(1,0,0,1,0, 1,0,0,1,2,0,0));
    tbl.push_back(v(1,0,0,1,1, 1,0,0,1,2,0,0));
    tbl.push_back(v(1,0,0,1,0, 1,1,4,1,1,0,0));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,2,0,1));
    tbl.push_back(v(1,1,5,1,0, 1,0,0,0,2,0,1));
    tbl.push_back(v(1,0,0,0,1, 1,0,0,1,2,0,0));
    tbl.push_back(v(1,0,0,1,0, 1,1,5,1,1,0,0));
    tbl.push_back(v(1,0,0,0,1, 1,0,0,0,2,0,1));
    tbl.push_back(v(1,0,0,0,1, 1,0,0,0,1,0,1));
    tbl.push_back(v(1,0,0,0,0, 1,0,0,0,0,0,1));

    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].inst, tbl[i].sv, tbl[i].id, tbl[i].mr, tbl[i].dn);
      #1;
      chk($sformatf("row%0d.s_ready", i), 32'(s_ready[tbl[i].inst]), 32'(tbl[i].esr));
      chk($sformatf("row%0d.m_valid", i), 32'(m_valid[tbl[i].inst]), 32'(tbl[i].emv));
      chk($sformatf("row%0d.fill", i),    32'(fill[tbl[i].inst]),    32'(tbl[i].efill));
      chk($sformatf("row%0d.outst", i),   32'(outst[tbl[i].inst]),   32'(tbl[i].eout));
      chk($sformatf("row%0d.full", i),    32'(full[tbl[i].inst]),    32'(tbl[i].efull));
      chk($sformatf("row%0d.empty", i),   32'(empty[tbl[i].inst]),   32'(tbl[i].eempty));
      if (tbl[i].emv) begin
        chk($sformatf("row%0d.m_id", i),   32'(m_id[tbl[i].inst]),   32'(tbl[i].eid));
        chk($sformatf("row%0d.m_addr", i), m_addr[tbl[i].inst],      addr_of(tbl[i].eid));
        chk($sformatf("row%0d.m_len", i),  32'(m_len[tbl[i].inst]),  32'(len_of(tbl[i].eid)));
      end
      step();
    end

    // depth 3 random push/pop with wrap, checked against a fill model and an order queue
    begin
      int model_fill = 0;
      logic [31:0] tag = 32'hA000;
      for (int c = 0; c < 30; c++) begin
        bit sv, mr, shs, mhs;
        sv = 1'($urandom_range(0, 1));
        mr = 1'($urandom_range(0, 1));
        clear_inputs();
        s_valid[2] = sv;
        s_addr[2]  = tag;
        m_ready[2] = mr;
        done[2]    = 1'b1;
        #1;
        chk($sformatf("wrap%0d.fill", c),    32'(fill[2]),    32'(model_fill));
        chk($sformatf("wrap%0d.m_valid", c), 32'(m_valid[2]), 32'(model_fill > 0));
        shs = sv && (model_fill < 3);
        mhs = mr && (model_fill > 0);
        if (mhs) begin
          if (exp_q.size() == 0) chk($sformatf("wrap%0d.queue", c), 32'd0, 32'd1);
          else chk($sformatf("wrap%0d.m_addr", c), m_addr[2], exp_q.pop_front());
        end
        if (shs) begin
          exp_q.push_back(tag);
          tag = tag + 32'h1;
        end
        model_fill = model_fill + (shs ? 1 : 0) - (mhs ? 1 : 0);
        step();
      end
      clear_inputs();
      #1;
      chk("wrap.final_fill", 32'(fill[2]), 32'(model_fill));
    end

    // reset in the middle of traffic on instance 0
    do_reset();
    drive(0, 1, 1, 0, 0); step();
    drive(0, 1, 2, 1, 0); step();
    drive(0, 1, 3, 0, 0); step();
    clear_inputs();
    #1;
    chk("pre_rst.fill",  32'(fill[0]),  32'd2);
    chk("pre_rst.outst", 32'(outst[0]), 32'd1);
    drive(0, 1, 4, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("in_rst.s_ready", 32'(s_ready[0]), 32'd0);
    chk("in_rst.m_valid", 32'(m_valid[0]), 32'd0);
    step();
    rst_n = 1'b1;
    clear_inputs();
    #1;
    chk("post_rst.fill",    32'(fill[0]),    32'd0);
    chk("post_rst.outst",   32'(outst[0]),   32'd0);
    chk("post_rst.empty",   32'(empty[0]),   32'd1);
    chk("post_rst.full",    32'(full[0]),    32'd0);
    chk("post_rst.m_valid", 32'(m_valid[0]), 32'd0);
    chk("post_rst.s_ready", 32'(s_ready[0]), 32'd1);
    drive(0, 1, 7, 0, 0); step();
    clear_inputs();
    #1;
    chk("post_rst.new_valid", 32'(m_valid[0]), 32'd1);
    chk("post_rst.new_id",    32'(m_id[0]),    32'd7);
    chk("post_rst.new_fill",  32'(fill[0]),    32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
